id_operand_stage: RTL and testbench

- Decode/operand-fetch stage sitting directly upstream of the two-read, one-write register file.
- Accepts fetched instructions over a valid/ready handshake and drives the register-file read addresses.
- Collects the registered read data one cycle later and fixes up write-after-read hazards with writeback bypass.
- Presents a registered ID/EX bundle (operands, immediate, destination, decode fields) to the execute stage.

---
 rtl/id_operand_stage.sv | 130 +++++++++++++
 tb/tb_id_operand_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// id_operand_stage: decode/operand-fetch stage feeding a registered ID/EX bundle
// Ports:
//   clk, rst_n (async, active-low), flush (sync kill of S1 and OUT)
//   in_valid/in_ready/in_instr/in_pc : fetched instruction handshake
//   rf_r1_addr/rf_r2_addr            : register-file read addresses (rs, rt)
//   rf_r1_dout/rf_r2_dout            : register-file read data, one cycle after address
//   wb_wr/wb_addr/wb_data            : writeback port shared with the register file
//   out_valid/out_ready              : ID/EX bundle handshake
//   out_pc/out_op_a/out_op_b/out_imm/out_rd/out_opcode/out_funct/out_shamt : bundle
module id_operand_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic [31:0]   in_pc,
    output logic [AW-1:0] rf_r1_addr,
    output logic [AW-1:0] rf_r2_addr,
    input  logic [DW-1:0] rf_r1_dout,
    input  logic [DW-1:0] rf_r2_dout,
    input  logic          wb_wr,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [DW-1:0] out_op_a,
    output logic [DW-1:0] out_op_b,
    output logic [31:0]   out_imm,
    output logic [AW-1:0] out_rd,
    output logic [5:0]    out_opcode,
    output logic [5:0]    out_funct,
    output logic [4:0]    out_shamt
);
    logic          s1_valid_q;
    logic [31:0]   s1_instr_q;
    logic [31:0]   s1_pc_q;
    logic          byp_a_v_q, byp_b_v_q;
    logic [DW-1:0] byp_a_d_q, byp_b_d_q;
    logic          s1_adv, accept;
    logic [AW-1:0] s1_rs, s1_rt;
    logic [5:0]    s1_op;
    logic [15:0]   s1_imm16;
    logic [DW-1:0] op_a_d, op_b_d;
    logic [31:0]   imm_d;
    logic [AW-1:0] rd_d;

    assign s1_adv   = s1_valid_q & (!out_valid | out_ready);
    assign in_ready = !s1_valid_q | s1_adv;
    assign accept   = in_valid & in_ready & !flush;

    assign s1_rs    = AW'(s1_instr_q[25:21]);
    assign s1_rt    = AW'(s1_instr_q[20:16]);
    assign s1_op    = s1_instr_q[31:26];
    assign s1_imm16 = s1_instr_q[15:0];

    // While S1 is stalled its registers are re-read every cycle so rf data stays current
    assign rf_r1_addr = in_ready ? AW'(in_instr[25:21]) : s1_rs;
    assign rf_r2_addr = in_ready ? AW'(in_instr[20:16]) : s1_rt;

    // R0 is forced here; a live write beats a write that collided with last cycle's read
    assign op_a_d = (s1_rs == '0) ? '0 : (wb_wr && wb_addr == s1_rs) ? wb_data :
                    byp_a_v_q ? byp_a_d_q : rf_r1_dout;
    assign op_b_d = (s1_rt == '0) ? '0 : (wb_wr && wb_addr == s1_rt) ? wb_data :
                    byp_b_v_q ? byp_b_d_q : rf_r2_dout;

    assign imm_d = (s1_op == 6'h0C || s1_op == 6'h0D || s1_op == 6'h0E) ? {16'h0, s1_imm16} :
                   (s1_op == 6'h0F) ? {s1_imm16, 16'h0} : {{16{s1_imm16[15]}}, s1_imm16};

    assign rd_d = (s1_op == 6'h00) ? AW'(s1_instr_q[15:11]) :
                  (s1_op == 6'h03) ? AW'(5'd31) : s1_rt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_instr_q <= '0;
            s1_pc_q    <= '0;
            byp_a_v_q  <= 1'b0;
            byp_b_v_q  <= 1'b0;
            byp_a_d_q  <= '0;
            byp_b_d_q  <= '0;
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_op_a   <= '0;
            out_op_b   <= '0;
            out_imm    <= '0;
            out_rd     <= '0;
            out_opcode <= '0;
            out_funct  <= '0;
            out_shamt  <= '0;
        end else begin
            byp_a_d_q <= wb_data;
            byp_b_d_q <= wb_data;
            if (flush) begin
                s1_valid_q <= 1'b0;
                out_valid  <= 1'b0;
                byp_a_v_q  <= 1'b0;
                byp_b_v_q  <= 1'b0;
            end else begin
                // The register file returns the pre-write value on a same-cycle read/write
                byp_a_v_q <= wb_wr & (wb_addr == rf_r1_addr);
                byp_b_v_q <= wb_wr & (wb_addr == rf_r2_addr);
                if (accept) begin
                    s1_valid_q <= 1'b1;
                    s1_instr_q <= in_instr;
                    s1_pc_q    <= in_pc;
                end else if (s1_adv) begin
                    s1_valid_q <= 1'b0;
                end
                if (s1_adv) begin
                    out_valid  <= 1'b1;
                    out_pc     <= s1_pc_q;
                    out_op_a   <= op_a_d;
                    out_op_b   <= op_b_d;
                    out_imm    <= imm_d;
                    out_rd     <= rd_d;
                    out_opcode <= s1_op;
                    out_funct  <= s1_instr_q[5:0];
                    out_shamt  <= s1_instr_q[10:6];
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed checks of id_operand_stage against a behavioural register file
module tb_id_operand_stage;
    logic        clk, rst_n, flush, in_valid, in_ready;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  rf_r1_addr, rf_r2_addr;
    logic [31:0] rf_r1_dout, rf_r2_dout;
    logic        wb_wr;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_op_a, out_op_b, out_imm;
    logic [4:0]  out_rd;
    logic [5:0]  out_opcode, out_funct;
    logic [4:0]  out_shamt;
    logic [31:0] regs [32];
    int pass, total;

    id_operand_stage #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rf_r1_addr(rf_r1_addr), .rf_r2_addr(rf_r2_addr),
        .rf_r1_dout(rf_r1_dout), .rf_r2_dout(rf_r2_dout),
        .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm(out_imm), .out_rd(out_rd),
        .out_opcode(out_opcode), .out_funct(out_funct), .out_shamt(out_shamt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read register file: a same-cycle read of a written address sees the old value
    always @(posedge clk) begin
        rf_r1_dout <= regs[rf_r1_addr];
        rf_r2_dout <= regs[rf_r2_addr];
        if (wb_wr) regs[wb_addr] <= wb_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b1; wb_wr = 1'b0; flush = 1'b0;
        step();
        step();
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_wr = 1'b1; wb_addr = a; wb_data = d;
        step();
        wb_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'h00221821; in_pc = 32'h0; wb_wr = 1'b0; wb_addr = '0; wb_data = '0;
        #3;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %h exp 0", out_valid); else pass++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %h exp 1", in_ready); else pass++;
        total++; if (out_op_a !== 32'h0 || out_imm !== 32'h0) $display("FAIL reset_out_data got %h/%h exp 0/0", out_op_a, out_imm); else pass++;
        total++; if (rf_r1_addr !== 5'd1 || rf_r2_addr !== 5'd2) $display("FAIL reset_rf_addr got %0d/%0d exp 1/2", rf_r1_addr, rf_r2_addr); else pass++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_stream();
        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd7);
        wb_write(5'd4, 32'h1111);
        wb_write(5'd5, 32'h22);
        step();
        in_valid = 1'b1; in_instr = 32'h00221821; in_pc = 32'h100; out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL stream_latency got %h exp 0", out_valid); else pass++;
        in_pc = 32'h104;
        step();
        total++; if (out_valid !== 1'b1) $display("FAIL stream_valid0 got %h exp 1", out_valid); else pass++;
        total++; if (out_op_a !== 32'd5 || out_op_b !== 32'd7) $display("FAIL stream_ops got %h/%h exp 5/7", out_op_a, out_op_b); else pass++;
        total++; if (out_rd !== 5'd3 || out_funct !== 6'h21 || out_opcode !== 6'h0 || out_shamt !== 5'd0) $display("FAIL stream_fields got rd %0d funct %h exp 3 21", out_rd, out_funct); else pass++;
        total++; if (out_pc !== 32'h100) $display("FAIL stream_pc0 got %h exp 100", out_pc); else pass++;
        in_pc = 32'h108;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h104) $display("FAIL stream_pc1 got %h/%h exp 1/104", out_valid, out_pc); else pass++;
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h108 || out_op_a !== 32'd5) $display("FAIL stream_pc2 got %h/%h exp 1/108", out_valid, out_pc); else pass++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL stream_drain got %h exp 0", out_valid); else pass++;
    endtask

    task automatic test_bypass();
        in_valid = 1'b1; in_instr = 32'h00853021; in_pc = 32'h200;
        wb_wr = 1'b1; wb_addr = 5'd4; wb_data = 32'hDEAD;
        step();
        in_valid = 1'b0; wb_addr = 5'd5; wb_data = 32'h77;
        step();
        wb_wr = 1'b0;
        total++; if (out_op_a !== 32'hDEAD) $display("FAIL bypass_captured got %h exp 0000dead", out_op_a); else pass++;
        total++; if (out_op_b !== 32'h77) $display("FAIL bypass_live got %h exp 00000077", out_op_b); else pass++;
        total++; if (out_rd !== 5'd6 || out_pc !== 32'h200) $display("FAIL bypass_fields got %0d/%h exp 6/200", out_rd, out_pc); else pass++;
        idle();
    endtask

    task automatic test_stall();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00221821; in_pc = 32'h300;
        step();
        in_instr = 32'h00224021; in_pc = 32'h304;
        step();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %h exp 0", in_ready); else pass++;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h300) $display("FAIL stall_out got %h/%h exp 1/300", out_valid, out_pc); else pass++;
        wb_write(5'd2, 32'h55);
        for (int i = 0; i < 2; i++) begin
            total++; if (out_pc !== 32'h300 || out_op_b !== 32'd7 || in_ready !== 1'b0) $display("FAIL stall_stable%0d got %h/%h/%h exp 300/7/0", i, out_pc, out_op_b, in_ready); else pass++;
            step();
        end
        total++; if (out_pc !== 32'h300 || out_valid !== 1'b1) $display("FAIL stall_stable2 got %h/%h exp 300/1", out_pc, out_valid); else pass++;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready got %h exp 1", in_ready); else pass++;
        step();
        total++; if (out_pc !== 32'h304 || out_rd !== 5'd8) $display("FAIL stall_next got %h/%0d exp 304/8", out_pc, out_rd); else pass++;
        total++; if (out_op_a !== 32'd5 || out_op_b !== 32'h55) $display("FAIL stall_refresh got %h/%h exp 5/55", out_op_a, out_op_b); else pass++;
        idle();
    endtask

    task automatic test_imm();
        wb_write(5'd0, 32'h1234);
        step();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h34058001; in_pc = 32'h400;
        step();
        in_instr = 32'h20268001; in_pc = 32'h404;
        step();
        total++; if (out_imm !== 32'h00008001) $display("FAIL imm_ori got %h exp 00008001", out_imm); else pass++;
        total++; if (out_op_a !== 32'h0 || out_rd !== 5'd5) $display("FAIL imm_r0 got %h/%0d exp 0/5", out_op_a, out_rd); else pass++;
        in_instr = 32'h3C07ABCD; in_pc = 32'h408;
        step();
        total++; if (out_imm !== 32'hFFFF8001 || out_op_a !== 32'd5 || out_rd !== 5'd6) $display("FAIL imm_addi got %h/%h exp ffff8001/5", out_imm, out_op_a); else pass++;
        in_valid = 1'b0;
        step();
        total++; if (out_imm !== 32'hABCD0000 || out_rd !== 5'd7 || out_pc !== 32'h408) $display("FAIL imm_lui got %h/%0d exp abcd0000/7", out_imm, out_rd); else pass++;
        idle();
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0C000010; in_pc = 32'h500;
        step();
        in_instr = 32'h34058001; in_pc = 32'h504;
        step();
        total++; if (out_rd !== 5'd31 || out_opcode !== 6'h03 || out_imm !== 32'h10) $display("FAIL jal_fields got %0d/%h/%h exp 31/03/10", out_rd, out_opcode, out_imm); else pass++;
        flush = 1'b1; in_instr = 32'h00221821; in_pc = 32'h508;
        step();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_clear got %h/%h exp 0/1", out_valid, in_ready); else pass++;
        flush = 1'b1; in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got %h exp 1", in_ready); else pass++;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL flush_no_stale0 got %h exp 0", out_valid); else pass++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL flush_no_stale1 got %h exp 0", out_valid); else pass++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00221821; in_pc = 32'h600;
        step();
        in_pc = 32'h604;
        step();
        total++; if (out_valid !== 1'b1) $display("FAIL rstmid_pre got %h exp 1", out_valid); else pass++;
        #1 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rstmid_ctrl got %h/%h exp 0/1", out_valid, in_ready); else pass++;
        total++; if (out_pc !== 32'h0 || out_op_a !== 32'h0 || out_op_b !== 32'h0 || out_rd !== 5'd0 || out_funct !== 6'h0) $display("FAIL rstmid_data got %h/%h/%h exp 0/0/0", out_pc, out_op_a, out_op_b); else pass++;
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rstmid_after got %h/%h exp 0/1", out_valid, in_ready); else pass++;
    endtask

    initial begin
        pass = 0; total = 0;
        test_reset();
        test_stream();
        test_bypass();
        test_stall();
        test_imm();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
